// File: rtl/fabric_arb_mux_if.sv
// Fabric link bundle: N request lanes, shared broadcast response payload with per-lane valid/ready.
// Instantiated with N=N_M on the master side and N=1, ID_W=SID_W on the target side.
interface fabric_arb_mux_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int OP_W   = 8,
  parameter int SIZE_W = 3,
  parameter int CODE_W = 8,
  parameter int ATTR_W = 4
);
  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_ready;
  logic [N*OP_W-1:0]         req_op;
  logic [N*ADDR_W-1:0]       req_addr;
  logic [N*DATA_W-1:0]       req_wdata;
  logic [N*(DATA_W/8)-1:0]   req_wstrb;
  logic [N*SIZE_W-1:0]       req_size;
  logic [N*ATTR_W-1:0]       req_attr;
  logic [N*ID_W-1:0]         req_id;
  logic [N-1:0]              rsp_valid;
  logic [N-1:0]              rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [CODE_W-1:0]         rsp_code;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
  );
endinterface

// File: rtl/fabric_arb_mux.sv
// N-master to 1-target request arbiter (1-cycle registered slice, RR or fixed priority, per-master
// outstanding limit) plus combinational response router; slice holds while s_req_ready is low.
module fabric_arb_mux #(
  parameter int N_M       = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int OP_W      = 8,
  parameter int SIZE_W    = 3,
  parameter int CODE_W    = 8,
  parameter int ATTR_W    = 4,
  parameter int MAX_OUTST = 4,
  parameter int ARB_RR    = 1,
  localparam int IDX_W    = (N_M > 1) ? $clog2(N_M) : 1,
  localparam int SID_W    = ID_W + IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fabric_arb_mux_if.slave      up,
  fabric_arb_mux_if.master     dn,
  output logic [N_M*4-1:0]     outst_cnt,
  output logic                 err_bad_rsp
);

  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [SIZE_W-1:0] size;
    logic [ATTR_W-1:0] attr;
    logic [SID_W-1:0]  id;
  } req_t;

  logic             s_vld_q, s_vld_d;
  req_t             req_q, req_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q [N_M];
  logic [3:0]       cnt_d [N_M];
  logic             err_q, err_d;

  logic             slot_free;
  logic [N_M-1:0]   elig;
  logic [N_M-1:0]   gnt;
  logic [N_M-1:0]   acc;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_elig;
  req_t             in_req;
  logic [ID_W-1:0]  id_sel;

  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_ok;
  logic             rsp_rdy_sel;
  logic [N_M-1:0]   rsp_hs;

  // ---------------- request arbitration ----------------
  always_comb begin : arb
    int j;
    j = 0;
    slot_free = !s_vld_q || dn.req_ready[0];
    for (int k = 0; k < N_M; k++) begin
      elig[k] = up.req_valid[k] && (cnt_q[k] < 4'(MAX_OUTST));
    end
    any_elig = 1'b0;
    gnt_idx  = '0;
    // Search starts at the pointer in RR mode and wraps; fixed mode always starts at 0.
    for (int i = 0; i < N_M; i++) begin
      j = (ARB_RR != 0) ? int'(ptr_q) + i : i;
      if (j >= N_M) j = j - N_M;
      if (!any_elig && elig[j]) begin
        any_elig = 1'b1;
        gnt_idx  = IDX_W'(j);
      end
    end
    gnt = any_elig ? (N_M'(1) << gnt_idx) : '0;
    acc = (slot_free && rst_n) ? gnt : '0;
  end

  assign up.req_ready = acc;

  always_comb begin : req_mux
    in_req = '0;
    id_sel = '0;
    for (int k = 0; k < N_M; k++) begin
      if (gnt[k]) begin
        in_req.op    = up.req_op[k*OP_W +: OP_W];
        in_req.addr  = up.req_addr[k*ADDR_W +: ADDR_W];
        in_req.wdata = up.req_wdata[k*DATA_W +: DATA_W];
        in_req.wstrb = up.req_wstrb[k*STRB_W +: STRB_W];
        in_req.size  = up.req_size[k*SIZE_W +: SIZE_W];
        in_req.attr  = up.req_attr[k*ATTR_W +: ATTR_W];
        id_sel       = up.req_id[k*ID_W +: ID_W];
      end
    end
    in_req.id = {gnt_idx, id_sel};
  end

  always_comb begin : slice_next
    int nxt;
    nxt     = int'(gnt_idx) + 1;
    if (nxt >= N_M) nxt = 0;
    s_vld_d = s_vld_q;
    req_d   = req_q;
    ptr_d   = ptr_q;
    if (|acc) begin
      s_vld_d = 1'b1;
      req_d   = in_req;
      if (ARB_RR != 0) ptr_d = IDX_W'(nxt);
    end else if (dn.req_ready[0]) begin
      s_vld_d = 1'b0;
    end
  end

  assign dn.req_valid = s_vld_q;
  assign dn.req_op    = req_q.op;
  assign dn.req_addr  = req_q.addr;
  assign dn.req_wdata = req_q.wdata;
  assign dn.req_wstrb = req_q.wstrb;
  assign dn.req_size  = req_q.size;
  assign dn.req_attr  = req_q.attr;
  assign dn.req_id    = req_q.id;

  // ---------------- response routing ----------------
  if (N_M == 1) begin : g_idx_one
    assign rsp_idx = '0;
    assign rsp_ok  = 1'b1;
  end else if (N_M == (1 << IDX_W)) begin : g_idx_pow2
    assign rsp_idx = dn.rsp_id[SID_W-1 -: IDX_W];
    assign rsp_ok  = 1'b1;
  end else begin : g_idx_npow2
    assign rsp_idx = dn.rsp_id[SID_W-1 -: IDX_W];
    assign rsp_ok  = (rsp_idx < IDX_W'(N_M));
  end

  always_comb begin : rsp_route
    up.rsp_valid = '0;
    rsp_rdy_sel  = 1'b0;
    for (int k = 0; k < N_M; k++) begin
      if (rsp_ok && (rsp_idx == IDX_W'(k))) begin
        up.rsp_valid[k] = dn.rsp_valid[0];
        rsp_rdy_sel     = up.rsp_ready[k];
      end
    end
    // Unroutable responses are swallowed so the target never deadlocks on them.
    dn.rsp_ready[0] = rsp_ok ? rsp_rdy_sel : 1'b1;
    err_d           = dn.rsp_valid[0] && !rsp_ok;
  end

  assign up.rsp_rdata = dn.rsp_rdata;
  assign up.rsp_code  = dn.rsp_code;
  assign up.rsp_id    = dn.rsp_id[ID_W-1:0];

  // ---------------- outstanding counters ----------------
  always_comb begin : cnt_next
    for (int k = 0; k < N_M; k++) begin
      rsp_hs[k] = up.rsp_valid[k] && up.rsp_ready[k];
      cnt_d[k]  = cnt_q[k];
      if (acc[k] && !rsp_hs[k]) begin
        cnt_d[k] = cnt_q[k] + 4'd1;
      end else if (!acc[k] && rsp_hs[k] && (cnt_q[k] != 4'd0)) begin
        cnt_d[k] = cnt_q[k] - 4'd1;
      end
    end
  end

  always_comb begin : cnt_out
    for (int k = 0; k < N_M; k++) begin
      outst_cnt[k*4 +: 4] = cnt_q[k];
    end
  end

  assign err_bad_rsp = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vld_q <= 1'b0;
      req_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < N_M; k++) cnt_q[k] <= '0;
    end else begin
      s_vld_q <= s_vld_d;
      req_q   <= req_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int k = 0; k < N_M; k++) cnt_q[k] <= cnt_d[k];
    end
  end

`ifdef CARBON_ENABLE_SVA
  localparam bit SVA_EN = 1'b1;
`elsif FORMAL
  localparam bit SVA_EN = 1'b1;
`else
  localparam bit SVA_EN = 1'b0;
`endif

  if (SVA_EN) begin : g_sva
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (dn.req_valid[0] && !dn.req_ready[0]) |=> (dn.req_valid[0] && $stable(req_q)));
    a_gnt_onehot: assert property (@(posedge clk) $onehot0(up.req_ready));
  end

endmodule

// File: tb/tb_fabric_arb_mux.sv
// Directed bench: instance A (4 masters, RR, limit 2) with request scoreboard; instance B
// (3 masters, fixed priority) for priority, unroutable-response and saturation cases.
module tb_fabric_arb_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [37:0] sbq [$];
  int          glog [$];

  logic [15:0] outst_cnt_a;
  logic        err_a;
  logic [11:0] outst_cnt_b;
  logic        err_b;

  fabric_arb_mux_if #(.N(4), .ID_W(4)) ua();
  fabric_arb_mux_if #(.N(1), .ID_W(6)) da();
  fabric_arb_mux_if #(.N(3), .ID_W(4)) ub();
  fabric_arb_mux_if #(.N(1), .ID_W(6)) db();

  fabric_arb_mux #(.N_M(4), .MAX_OUTST(2), .ARB_RR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .up(ua), .dn(da), .outst_cnt(outst_cnt_a), .err_bad_rsp(err_a)
  );

  fabric_arb_mux #(.N_M(3), .MAX_OUTST(4), .ARB_RR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .up(ub), .dn(db), .outst_cnt(outst_cnt_b), .err_bad_rsp(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pop on downstream handshake, then push whatever the masters hand over this cycle.
  task automatic mon_a();
    logic [37:0] e;
    if (da.req_valid[0] && da.req_ready[0]) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_s_req_id", 64'(da.req_id), 64'(e[37:32]));
        chk("sb_s_req_addr", 64'(da.req_addr), 64'(e[31:0]));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (ua.req_valid[k] && ua.req_ready[k]) begin
        sbq.push_back({2'(k), ua.req_id[k*4 +: 4], ua.req_addr[k*32 +: 32]});
        glog.push_back(k);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon_a();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic v, input logic [3:0] id, input logic [31:0] addr);
    ua.req_valid[k]        = v;
    ua.req_id[k*4 +: 4]    = id;
    ua.req_addr[k*32 +: 32] = addr;
  endtask

  task automatic set_b(input int k, input logic v, input logic [3:0] id, input logic [31:0] addr);
    ub.req_valid[k]        = v;
    ub.req_id[k*4 +: 4]    = id;
    ub.req_addr[k*32 +: 32] = addr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    sbq.delete();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    ua.req_valid = '0; ua.req_op = '0; ua.req_addr = '0; ua.req_wdata = '0; ua.req_wstrb = '0;
    ua.req_size = '0; ua.req_attr = '0; ua.req_id = '0; ua.rsp_ready = '0;
    da.req_ready = '0; da.rsp_valid = '0; da.rsp_rdata = '0; da.rsp_code = '0; da.rsp_id = '0;
    ub.req_valid = '0; ub.req_op = '0; ub.req_addr = '0; ub.req_wdata = '0; ub.req_wstrb = '0;
    ub.req_size = '0; ub.req_attr = '0; ub.req_id = '0; ub.rsp_ready = '0;
    db.req_ready = '0; db.rsp_valid = '0; db.rsp_rdata = '0; db.rsp_code = '0; db.rsp_id = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_s_req_valid", 64'(da.req_valid), 64'd0);
    chk("rst_m_req_ready", 64'(ua.req_ready), 64'd0);
    chk("rst_outst_a", 64'(outst_cnt_a), 64'd0);
    chk("rst_err_a", 64'(err_a), 64'd0);
    chk("rst_outst_b", 64'(outst_cnt_b), 64'd0);
    chk("rst_s_req_valid_b", 64'(db.req_valid), 64'd0);
    rst_n = 1'b1;

    // Single read from master 0, then its response
    da.req_ready = 1'b1;
    ua.rsp_ready = 4'hf;
    set_a(0, 1'b1, 4'd3, 32'h100);
    #1;
    chk("t1_grant", 64'(ua.req_ready), 64'b0001);
    cyc();
    set_a(0, 1'b0, 4'd3, 32'h100);
    chk("t1_s_req_valid", 64'(da.req_valid), 64'd1);
    chk("t1_s_req_id", 64'(da.req_id), 64'h03);
    chk("t1_s_req_addr", 64'(da.req_addr), 64'h100);
    chk("t1_outst0", 64'(outst_cnt_a[3:0]), 64'd1);
    cyc();
    chk("t1_slice_drained", 64'(da.req_valid), 64'd0);
    da.rsp_valid = 1'b1; da.rsp_id = 6'h03; da.rsp_rdata = 32'hdeadbeef; da.rsp_code = 8'h5a;
    #1;
    chk("t1_m_rsp_valid", 64'(ua.rsp_valid), 64'b0001);
    chk("t1_m_rsp_id", 64'(ua.rsp_id), 64'd3);
    chk("t1_m_rsp_rdata", 64'(ua.rsp_rdata), 64'hdeadbeef);
    chk("t1_m_rsp_code", 64'(ua.rsp_code), 64'h5a);
    chk("t1_s_rsp_ready", 64'(da.rsp_ready), 64'd1);
    cyc();
    da.rsp_valid = 1'b0;
    chk("t1_outst0_back", 64'(outst_cnt_a[3:0]), 64'd0);

    // Round-robin order with all masters requesting
    do_reset();
    glog.delete();
    for (int k = 0; k < 4; k++) set_a(k, 1'b1, 4'(k), 32'h1000 + 32'(k));
    for (int c = 0; c < 5; c++) cyc();
    for (int k = 0; k < 4; k++) set_a(k, 1'b0, 4'(k), 32'h0);
    cyc(); cyc();
    chk("t2_grant_count", 64'(glog.size()), 64'd5);
    if (glog.size() == 5) begin
      chk("t2_g0", 64'(glog[0]), 64'd0);
      chk("t2_g1", 64'(glog[1]), 64'd1);
      chk("t2_g2", 64'(glog[2]), 64'd2);
      chk("t2_g3", 64'(glog[3]), 64'd3);
      chk("t2_g4", 64'(glog[4]), 64'd0);
    end
    chk("t2_outst", 64'(outst_cnt_a), 64'h1112);

    // Outstanding limit on master 1
    do_reset();
    set_a(1, 1'b1, 4'd1, 32'h1010);
    #1;
    chk("t4_acc1", 64'(ua.req_ready), 64'b0010);
    cyc();
    set_a(1, 1'b1, 4'd2, 32'h1020);
    #1;
    chk("t4_acc2", 64'(ua.req_ready), 64'b0010);
    cyc();
    set_a(1, 1'b1, 4'd3, 32'h1030);
    #1;
    chk("t4_stall", 64'(ua.req_ready), 64'b0000);
    chk("t4_outst1_full", 64'(outst_cnt_a[7:4]), 64'd2);
    cyc(); cyc();
    chk("t4_still_stalled", 64'(ua.req_ready), 64'b0000);
    da.rsp_valid = 1'b1; da.rsp_id = {2'd1, 4'd1};
    #1;
    chk("t4_rsp_route", 64'(ua.rsp_valid), 64'b0010);
    chk("t4_stall_during_rsp", 64'(ua.req_ready), 64'b0000);
    cyc();
    da.rsp_valid = 1'b0;
    #1;
    chk("t4_released", 64'(ua.req_ready), 64'b0010);
    cyc();
    set_a(1, 1'b0, 4'd0, 32'h0);
    chk("t4_outst1_after", 64'(outst_cnt_a[7:4]), 64'd2);

    // Accept and response on master 2 in the same cycle
    set_a(2, 1'b1, 4'd2, 32'h2000);
    cyc();
    chk("t6_outst2_one", 64'(outst_cnt_a[11:8]), 64'd1);
    set_a(2, 1'b1, 4'd4, 32'h2040);
    da.rsp_valid = 1'b1; da.rsp_id = {2'd2, 4'd2};
    #1;
    chk("t6_acc2", 64'(ua.req_ready), 64'b0100);
    chk("t6_rsp2", 64'(ua.rsp_valid), 64'b0100);
    cyc();
    set_a(2, 1'b0, 4'd0, 32'h0);
    da.rsp_valid = 1'b0;
    chk("t6_outst2_same", 64'(outst_cnt_a[11:8]), 64'd1);
    cyc();

    // Downstream backpressure with a full slice
    da.req_ready = 1'b0;
    set_a(0, 1'b1, 4'd5, 32'h500);
    #1;
    chk("t3_acc0", 64'(ua.req_ready), 64'b0001);
    cyc();
    set_a(0, 1'b0, 4'd0, 32'h0);
    set_a(3, 1'b1, 4'd7, 32'h700);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_no_grant", 64'(ua.req_ready), 64'b0000);
      chk("t3_hold_valid", 64'(da.req_valid), 64'd1);
      chk("t3_hold_id", 64'(da.req_id), 64'h05);
      chk("t3_hold_addr", 64'(da.req_addr), 64'h500);
      cyc();
    end
    da.req_ready = 1'b1;
    #1;
    chk("t3_release_grant", 64'(ua.req_ready), 64'b1000);
    cyc();
    set_a(3, 1'b0, 4'd0, 32'h0);
    chk("t3_next_id", 64'(da.req_id), 64'h37);
    chk("t3_next_addr", 64'(da.req_addr), 64'h700);

    // Reset with a full slice
    da.req_ready = 1'b0;
    cyc();
    chk("t6_slice_full", 64'(da.req_valid), 64'd1);
    set_a(2, 1'b1, 4'd9, 32'h900);
    rst_n = 1'b0;
    #1;
    chk("t6_ready_in_reset", 64'(ua.req_ready), 64'b0000);
    cyc();
    sbq.delete();
    chk("t6_rst_valid", 64'(da.req_valid), 64'd0);
    chk("t6_rst_outst", 64'(outst_cnt_a), 64'd0);
    set_a(2, 1'b0, 4'd0, 32'h0);
    rst_n = 1'b1;
    da.req_ready = 1'b1;
    cyc();

    // Fixed priority on instance B
    db.req_ready = 1'b1;
    ub.rsp_ready = 3'b111;
    set_b(0, 1'b1, 4'd1, 32'ha0);
    set_b(1, 1'b1, 4'd2, 32'ha1);
    set_b(2, 1'b1, 4'd3, 32'ha2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("b_fixed_grant", 64'(ub.req_ready), 64'b001);
      cyc();
      chk("b_s_req_id", 64'(db.req_id), 64'h01);
    end
    for (int k = 0; k < 3; k++) set_b(k, 1'b0, 4'd0, 32'h0);
    cyc();
    chk("b_outst", 64'(outst_cnt_b), 64'h003);

    // Unroutable response index
    db.rsp_valid = 1'b1; db.rsp_id = 6'h31;
    #1;
    chk("b_bad_no_valid", 64'(ub.rsp_valid), 64'b000);
    chk("b_bad_ready", 64'(db.rsp_ready), 64'd1);
    chk("b_err_not_yet", 64'(err_b), 64'd0);
    cyc();
    chk("b_err_pulse", 64'(err_b), 64'd1);
    chk("b_bad_no_cnt", 64'(outst_cnt_b), 64'h003);

    // Response to an idle master saturates at zero; ready follows the addressed master
    db.rsp_id = 6'h25;
    ub.rsp_ready = 3'b011;
    #1;
    chk("b_route2_valid", 64'(ub.rsp_valid), 64'b100);
    chk("b_route2_id", 64'(ub.rsp_id), 64'd5);
    chk("b_route2_ready_low", 64'(db.rsp_ready), 64'd0);
    ub.rsp_ready = 3'b111;
    #1;
    chk("b_route2_ready_high", 64'(db.rsp_ready), 64'd1);
    cyc();
    chk("b_err_cleared", 64'(err_b), 64'd0);
    chk("b_sat_zero", 64'(outst_cnt_b), 64'h003);
    db.rsp_id = 6'h01;
    cyc();
    db.rsp_valid = 1'b0;
    chk("b_dec0", 64'(outst_cnt_b), 64'h002);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
